// File: rtl/bitonic_seq_sorter_pkg.sv
// Shared types and helpers for the sequential bitonic sorter.
package bitonic_seq_sorter_pkg;

  // Controller phases; the unused 2'd3 code falls back to LOAD.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One compare-exchange per cycle: (n/2) pairs per pass, lg*(lg+1)/2 passes.
  function automatic int sort_cycles(input int n);
    int lg;
    lg = $clog2(n);
    return (n / 2) * lg * (lg + 1) / 2;
  endfunction

endpackage

// File: rtl/bitonic_seq_sorter_as.sv
// Compare-exchange cell: lo gets the smaller word, hi the larger.
// On equality in1 is routed to lo.
module bitonic_seq_sorter_as #(
  parameter int W = 8
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  // Unsigned min/max of the two inputs
  always_comb begin
    lo = (in1 <= in2) ? in1 : in2;
    hi = (in1 <= in2) ? in2 : in1;
  end

endmodule

// File: rtl/bitonic_seq_sorter.sv
// Sequential bitonic sorter: load N words, sort in place with one shared
// compare-exchange cell, then stream them out smallest first.
module bitonic_seq_sorter
  import bitonic_seq_sorter_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int SORT_CYC = sort_cycles(N);
  localparam int CW       = $clog2(SORT_CYC + 1);
  localparam int SW       = (LOGN > 1) ? $clog2(LOGN) : 1;

  state_t            state, state_nx;
  logic [W-1:0]      mem [N];
  logic [LOGN-1:0]   wr_ptr, rd_ptr;
  logic [LOGN:0]     i;          // lower index of the current pair
  logic [SW-1:0]     ks;         // k = 2 << ks
  logic [SW-1:0]     js;         // j = 1 << js
  logic [CW-1:0]     cyc;        // compare count within SORT

  logic [LOGN:0]     j, k, l, inc, nxt_i;
  logic [W-1:0]      cell_lo, cell_hi;
  logic              asc, accept, xfer, sort_done, pass_end;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == SORT);
  assign out_data  = (state == DRAIN) ? mem[rd_ptr] : '0;

  assign accept = in_valid && (state == LOAD);
  assign xfer   = out_ready && (state == DRAIN);

  // Pair sequencing: partner index, direction and next valid lower index.
  // Indices with bit j set are upper partners, so the step jumps over them.
  always_comb begin
    j         = (LOGN + 1)'(1) << js;
    k         = (LOGN + 1)'(2) << ks;
    l         = i ^ j;
    asc       = ((i & k) == '0);
    inc       = i + 1'b1;
    nxt_i     = ((inc & j) != '0) ? inc + j : inc;
    pass_end  = nxt_i[LOGN];
    sort_done = (cyc == CW'(SORT_CYC - 1));
  end

  bitonic_seq_sorter_as #(.W(W)) u_as (
    .in1 (mem[i[LOGN-1:0]]),
    .in2 (mem[l[LOGN-1:0]]),
    .lo  (cell_lo),
    .hi  (cell_hi)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Phase transitions: full frame in, last compare done, last word out
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && wr_ptr == LOGN'(N - 1)) state_nx = SORT;
      SORT:    if (sort_done) state_nx = DRAIN;
      DRAIN:   if (xfer && rd_ptr == LOGN'(N - 1)) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Buffer writes, pointers and the k/j/i sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) mem[n] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      i      <= '0;
      ks     <= '0;
      js     <= '0;
      cyc    <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      if (state == SORT) begin
        mem[i[LOGN-1:0]] <= asc ? cell_lo : cell_hi;
        mem[l[LOGN-1:0]] <= asc ? cell_hi : cell_lo;
        if (sort_done) begin
          cyc <= '0;
          i   <= '0;
          ks  <= '0;
          js  <= '0;
        end else begin
          cyc <= cyc + 1'b1;
          if (pass_end) begin
            i <= '0;
            if (js == '0) begin
              ks <= ks + 1'b1;
              js <= ks + 1'b1;
            end else begin
              js <= js - 1'b1;
            end
          end else begin
            i <= nxt_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bitonic_seq_sorter.sv
// Directed bench for the sequential bitonic sorter.
module tb_bitonic_seq_sorter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data, out_data;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int rdy_seen;
  int acc_cyc;

  bitonic_seq_sorter #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Offer a frame; with gaps, in_valid drops for a cycle before each word.
  task automatic send(input logic [7:0] d [8], input bit gaps);
    for (int n = 0; n < 8; n++) begin
      int t;
      if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d[n];
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("send_timeout", 32'(n), 32'd8);
      acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Drain a frame; with bp, out_ready follows 1,0,0 repeating.
  task automatic recv(input logic [7:0] e [8], input bit bp);
    int n = 0;
    int t = 0;
    bit pend = 1'b0;
    logic [7:0] held = '0;
    while (n < 8 && t < 300) begin
      out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      if (in_ready) rdy_seen++;
      if (out_valid) begin
        if (pend) chk("hold_stable", 32'(out_data), 32'(held));
        if (out_ready) begin
          chk($sformatf("out%0d", n), 32'(out_data), 32'(e[n]));
          n++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = out_data;
        end
      end
      @(negedge clk);
      t++;
    end
    if (n < 8) chk("recv_timeout", 32'(n), 32'd8);
    out_ready = 1'b0;
  endtask

  initial begin
    int t, bc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reverse frame: latency and SORT duration
    send('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    bc = 0; t = 0;
    while (!out_valid && t < 100) begin
      if (busy) bc++;
      @(negedge clk);
      t++;
    end
    chk("first_out_latency", 32'(cyc - acc_cyc), 32'd25);
    chk("busy_cycles",       32'(bc),            32'd24);
    recv('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);

    // Duplicates and extremes
    send('{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1}, 1'b0);
    recv('{8'd0, 8'd0, 8'd1, 8'd5, 8'd5, 8'd5, 8'd255, 8'd255}, 1'b0);

    // Backpressure on the output
    send('{8'd40, 8'd10, 8'd80, 8'd20, 8'd70, 8'd30, 8'd60, 8'd50}, 1'b0);
    recv('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 1'b1);

    // Input gaps, then junk offered during SORT/DRAIN must not be taken
    send('{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6}, 1'b1);
    in_valid = 1'b1; in_data = 8'hEE;
    recv('{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9}, 1'b0);
    in_valid = 1'b0;

    // Reset ten cycles into SORT
    send('{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, 1'b0);
    bc = 0; t = 0;
    while (bc < 10 && t < 100) begin
      if (busy) bc++;
      @(negedge clk);
      t++;
    end
    chk("sort_reached", 32'(bc), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send('{8'h80, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'h00, 8'hC0, 8'h3F}, 1'b0);
    recv('{8'h00, 8'h01, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hC0, 8'hFE}, 1'b0);

    // Back-to-back frames with in_valid held high
    send('{8'd2, 8'd4, 8'd6, 8'd8, 8'd1, 8'd3, 8'd5, 8'd7}, 1'b0);
    in_valid = 1'b1; in_data = 8'd200;
    rdy_seen = 0;
    recv('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);
    chk("no_ready_until_load", 32'(rdy_seen), 32'd0);
    send('{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd25, 8'd75}, 1'b0);
    recv('{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd150, 8'd200, 8'd250}, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
